// File: rtl/sys_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sys_pkg
//  Description : Shared constants and state encoding for the system command
//                sequencer (command codes, operand addresses, FSM states).
//  Revision    : 1.0 - initial release
// ============================================================================
package sys_pkg;

    // Command bytes recognised in IDLE
    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    // Register-file locations holding the ALU operands
    localparam int OPA_ADDR = 0;
    localparam int OPB_ADDR = 1;

    // Sequencer states
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WR_ADDR  = 4'd1,
        ST_WR_DATA  = 4'd2,
        ST_RD_ADDR  = 4'd3,
        ST_RD_WAIT  = 4'd4,
        ST_ALU_A    = 4'd5,
        ST_ALU_B    = 4'd6,
        ST_ALU_FUN  = 4'd7,
        ST_ALU_WAIT = 4'd8,
        ST_TX_RD    = 4'd9,
        ST_TX_LO    = 4'd10,
        ST_TX_HI    = 4'd11
    } state_t;

endpackage : sys_pkg
`default_nettype wire

// File: rtl/sys_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sys_cmd_ctrl
//  Description : Byte-frame command sequencer. Decodes frames from the UART
//                RX path, drives register-file writes/reads and ALU
//                operations, and pushes responses into the TX FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module sys_cmd_ctrl
    import sys_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 4,
    parameter int FUN_WIDTH    = 4,
    parameter int WAIT_TIMEOUT = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    // RX byte stream
    input  logic [DATA_WIDTH-1:0]     i_rx_p_data,
    input  logic                      i_rx_d_vld,
    // Register file
    output logic [ADDR_WIDTH-1:0]     o_rf_addr,
    output logic                      o_rf_wr_en,
    output logic                      o_rf_rd_en,
    output logic [DATA_WIDTH-1:0]     o_rf_wr_data,
    input  logic [DATA_WIDTH-1:0]     i_rf_rd_data,
    input  logic                      i_rf_rd_vld,
    // ALU
    output logic [FUN_WIDTH-1:0]      o_alu_fun,
    output logic                      o_alu_en,
    output logic                      o_alu_clk_en,
    input  logic [2*DATA_WIDTH-1:0]   i_alu_out,
    input  logic                      i_alu_out_vld,
    // TX FIFO
    output logic [DATA_WIDTH-1:0]     o_tx_p_data,
    output logic                      o_tx_d_vld,
    input  logic                      i_fifo_full,
    // Error indication
    output logic                      o_cmd_err
);

    // Counter wide enough to hold WAIT_TIMEOUT-1
    localparam int c_cnt_w = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WAIT_TIMEOUT - 1);

    state_t                    r_state;
    logic [ADDR_WIDTH-1:0]     r_wr_addr;
    logic [DATA_WIDTH-1:0]     r_rd_data;
    logic [2*DATA_WIDTH-1:0]   r_alu_res;
    logic [c_cnt_w-1:0]        r_cnt;

    logic                      w_cmd_wr;
    logic                      w_cmd_rd;
    logic                      w_cmd_alu;
    logic                      w_cmd_nop;
    logic                      w_timeout;
    logic [ADDR_WIDTH-1:0]     w_byte_addr;
    logic [FUN_WIDTH-1:0]      w_byte_fun;

    assign w_cmd_wr    = (i_rx_p_data == DATA_WIDTH'(CMD_RF_WR));
    assign w_cmd_rd    = (i_rx_p_data == DATA_WIDTH'(CMD_RF_RD));
    assign w_cmd_alu   = (i_rx_p_data == DATA_WIDTH'(CMD_ALU_OP));
    assign w_cmd_nop   = (i_rx_p_data == DATA_WIDTH'(CMD_ALU_NOP));
    // Last waiting cycle: a response arriving now still wins over the abort
    assign w_timeout   = (r_cnt == c_cnt_last);
    assign w_byte_addr = i_rx_p_data[ADDR_WIDTH-1:0];
    assign w_byte_fun  = i_rx_p_data[FUN_WIDTH-1:0];

    // Frame sequencer: decodes bytes, issues strobes, waits for results, transmits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_wr_addr    <= '0;
            r_rd_data    <= '0;
            r_alu_res    <= '0;
            r_cnt        <= '0;
            o_rf_addr    <= '0;
            o_rf_wr_en   <= 1'b0;
            o_rf_rd_en   <= 1'b0;
            o_rf_wr_data <= '0;
            o_alu_fun    <= '0;
            o_alu_en     <= 1'b0;
            o_alu_clk_en <= 1'b0;
            o_tx_p_data  <= '0;
            o_tx_d_vld   <= 1'b0;
            o_cmd_err    <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below
            o_rf_wr_en <= 1'b0;
            o_rf_rd_en <= 1'b0;
            o_alu_en   <= 1'b0;
            o_tx_d_vld <= 1'b0;
            o_cmd_err  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (i_rx_d_vld) begin
                        if (w_cmd_wr) begin
                            r_state <= ST_WR_ADDR;
                        end else if (w_cmd_rd) begin
                            r_state <= ST_RD_ADDR;
                        end else if (w_cmd_alu) begin
                            r_state <= ST_ALU_A;
                        end else if (w_cmd_nop) begin
                            // Gate opens on entry so the ALU is clocked before ALU_EN
                            r_state      <= ST_ALU_FUN;
                            o_alu_clk_en <= 1'b1;
                        end else begin
                            o_cmd_err <= 1'b1;
                        end
                    end
                end

                ST_WR_ADDR: begin
                    if (i_rx_d_vld) begin
                        r_wr_addr <= w_byte_addr;
                        r_state   <= ST_WR_DATA;
                    end
                end

                ST_WR_DATA: begin
                    if (i_rx_d_vld) begin
                        o_rf_wr_en   <= 1'b1;
                        o_rf_addr    <= r_wr_addr;
                        o_rf_wr_data <= i_rx_p_data;
                        r_state      <= ST_IDLE;
                    end
                end

                ST_RD_ADDR: begin
                    if (i_rx_d_vld) begin
                        o_rf_rd_en <= 1'b1;
                        o_rf_addr  <= w_byte_addr;
                        r_cnt      <= '0;
                        r_state    <= ST_RD_WAIT;
                    end
                end

                ST_RD_WAIT: begin
                    if (i_rf_rd_vld) begin
                        r_rd_data <= i_rf_rd_data;
                        r_cnt     <= '0;
                        r_state   <= ST_TX_RD;
                    end else if (w_timeout) begin
                        o_cmd_err <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_ALU_A: begin
                    if (i_rx_d_vld) begin
                        o_rf_wr_en   <= 1'b1;
                        o_rf_addr    <= ADDR_WIDTH'(OPA_ADDR);
                        o_rf_wr_data <= i_rx_p_data;
                        r_state      <= ST_ALU_B;
                    end
                end

                ST_ALU_B: begin
                    if (i_rx_d_vld) begin
                        o_rf_wr_en   <= 1'b1;
                        o_rf_addr    <= ADDR_WIDTH'(OPB_ADDR);
                        o_rf_wr_data <= i_rx_p_data;
                        o_alu_clk_en <= 1'b1;
                        r_state      <= ST_ALU_FUN;
                    end
                end

                ST_ALU_FUN: begin
                    if (i_rx_d_vld) begin
                        o_alu_fun <= w_byte_fun;
                        o_alu_en  <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= ST_ALU_WAIT;
                    end
                end

                ST_ALU_WAIT: begin
                    if (i_alu_out_vld) begin
                        r_alu_res    <= i_alu_out;
                        o_alu_clk_en <= 1'b0;
                        r_cnt        <= '0;
                        r_state      <= ST_TX_LO;
                    end else if (w_timeout) begin
                        o_cmd_err    <= 1'b1;
                        o_alu_clk_en <= 1'b0;
                        r_cnt        <= '0;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_TX_RD: begin
                    if (!i_fifo_full) begin
                        o_tx_d_vld  <= 1'b1;
                        o_tx_p_data <= r_rd_data;
                        r_state     <= ST_IDLE;
                    end
                end

                ST_TX_LO: begin
                    if (!i_fifo_full) begin
                        o_tx_d_vld  <= 1'b1;
                        o_tx_p_data <= r_alu_res[DATA_WIDTH-1:0];
                        r_state     <= ST_TX_HI;
                    end
                end

                ST_TX_HI: begin
                    if (!i_fifo_full) begin
                        o_tx_d_vld  <= 1'b1;
                        o_tx_p_data <= r_alu_res[2*DATA_WIDTH-1:DATA_WIDTH];
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state      <= ST_IDLE;
                    o_alu_clk_en <= 1'b0;
                    r_cnt        <= '0;
                end
            endcase
        end
    end

endmodule : sys_cmd_ctrl
`default_nettype wire
